// File: rtl/legv8_alu_seq.sv
// legv8_alu_seq: handshaked LEGv8 execute unit with internal ALU-control decode.
// Single-cycle ops finish on the accept edge. MUL is an iterative shift-add unit.
// The optional restoring UDIV divider is built only when LEGV8_ALU_UDIV_EN is defined;
// without it, the UDIV opcode decodes as illegal.
module legv8_alu_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [10:0]      Opcode_field,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             Zero,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned W1  = WIDTH + 1;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_UDIV = 11'b10011010110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR,
    OP_PASS, OP_MUL, OP_UDIV, OP_ILL
  } op_t;

  state_t             state;
  op_t                op;
  logic               accept;

  logic [WIDTH-1:0]   b_eff;
  logic [W1-1:0]      sum;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic               sc_ill;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_acc_next;

`ifdef LEGV8_ALU_UDIV_EN
  logic [WIDTH-1:0]   div_q;
  logic [W1-1:0]      div_r;
  logic [WIDTH-1:0]   div_d;
  logic [W1-1:0]      div_shift;
  logic               div_ge;
  logic [W1-1:0]      div_r_next;
  logic [WIDTH-1:0]   div_q_next;
`endif

  // A new operation can enter when idle, or when the held result is consumed this cycle.
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // ALU-control decode: ALUOp selects add / pass-B / R-type opcode field.
  always_comb begin
    op = OP_ADD;
    case (ALUOp)
      2'b01: op = OP_PASS;
      2'b10: begin
        case (Opcode_field)
          OPC_ADD:  op = OP_ADD;
          OPC_SUB:  op = OP_SUB;
          OPC_AND:  op = OP_AND;
          OPC_ORR:  op = OP_ORR;
          OPC_EOR:  op = OP_EOR;
          OPC_LSL:  op = OP_LSL;
          OPC_LSR:  op = OP_LSR;
          OPC_MUL:  op = OP_MUL;
`ifdef LEGV8_ALU_UDIV_EN
          OPC_UDIV: op = OP_UDIV;
`else
          OPC_UDIV: op = OP_ILL;
`endif
          default:  op = OP_ILL;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  // Single-cycle datapath: adder with carry/overflow, logic ops, shifts, pass-B.
  always_comb begin
    b_eff  = (op == OP_SUB) ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_eff} + W1'(op == OP_SUB);
    shamt  = B[SHW-1:0];
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_ill = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (A[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  sc_res = A & B;
      OP_ORR:  sc_res = A | B;
      OP_EOR:  sc_res = A ^ B;
      OP_LSL:  sc_res = A << shamt;
      OP_LSR:  sc_res = A >> shamt;
      OP_PASS: sc_res = B;
      OP_UDIV: sc_res = '0;  // divide by zero short-cut
      OP_ILL:  sc_ill = 1'b1;
      default: sc_res = '0;
    endcase
  end

  // Shift-add step: add the multiplicand when the current multiplier bit is set.
  always_comb begin
    mul_acc_next = mul_b[0] ? (mul_acc + mul_a) : mul_acc;
  end

`ifdef LEGV8_ALU_UDIV_EN
  // Restoring divide step: shift in next dividend bit, subtract divisor if it fits.
  always_comb begin
    div_shift  = {div_r[WIDTH-1:0], div_q[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, div_d});
    div_r_next = div_ge ? (div_shift - {1'b0, div_d}) : div_shift;
    div_q_next = {div_q[WIDTH-2:0], div_ge};
  end
`endif

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ALU_result <= '0;
      Zero       <= 1'b1;
      N          <= 1'b0;
      C          <= 1'b0;
      V          <= 1'b0;
      illegal    <= 1'b0;
      out_valid  <= 1'b0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_acc    <= '0;
`ifdef LEGV8_ALU_UDIV_EN
      div_q      <= '0;
      div_r      <= '0;
      div_d      <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mul_a     <= A;
              mul_b     <= B;
              mul_acc   <= '0;
              cnt       <= CW'(WIDTH);
              out_valid <= 1'b0;
              state     <= MUL;
            end
`ifdef LEGV8_ALU_UDIV_EN
            else if ((op == OP_UDIV) && (B != '0)) begin
              div_q     <= A;
              div_r     <= '0;
              div_d     <= B;
              cnt       <= CW'(WIDTH);
              out_valid <= 1'b0;
              state     <= DIV;
            end
`endif
            else begin
              ALU_result <= sc_res;
              Zero       <= (sc_res == '0);
              N          <= sc_res[WIDTH-1];
              C          <= sc_c;
              V          <= sc_v;
              illegal    <= sc_ill;
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MUL: begin
          mul_acc <= mul_acc_next;
          mul_a   <= {mul_a[WIDTH-2:0], 1'b0};
          mul_b   <= {1'b0, mul_b[WIDTH-1:1]};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            ALU_result <= mul_acc_next;
            Zero       <= (mul_acc_next == '0);
            N          <= mul_acc_next[WIDTH-1];
            C          <= 1'b0;
            V          <= 1'b0;
            illegal    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
`ifdef LEGV8_ALU_UDIV_EN
        DIV: begin
          div_r <= div_r_next;
          div_q <= div_q_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            ALU_result <= div_q_next;
            Zero       <= (div_q_next == '0);
            N          <= div_q_next[WIDTH-1];
            C          <= 1'b0;
            V          <= 1'b0;
            illegal    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_alu_seq.sv
// tb_legv8_alu_seq: directed self-checking bench for legv8_alu_seq (WIDTH=64).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_legv8_alu_seq;

  localparam int unsigned W = 64;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_UDIV = 11'b10011010110;
  localparam logic [10:0] OPC_BAD  = 11'b11111111111;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   ALUOp;
  logic [10:0]  Opcode_field;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_result;
  logic         Zero, N, C, V, illegal;

  int total = 0;
  int passed = 0;

  legv8_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .Opcode_field(Opcode_field), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_result(ALU_result),
    .Zero(Zero), .N(N), .C(C), .V(V), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Present one request for one rising edge, then withdraw it.
  task automatic issue(input logic [1:0] op, input logic [10:0] opc,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = op; Opcode_field = opc; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count falling edges since acceptance until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ALUOp = 2'b00; Opcode_field = '0; A = '0; B = '0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({out_valid, in_ready, Zero, N, C, V, illegal} !== 7'b0110000 || ALU_result !== '0)
      $display("FAIL reset_state: ov=%b ir=%b Z=%b N=%b C=%b V=%b ill=%b res=%h",
               out_valid, in_ready, Zero, N, C, V, illegal, ALU_result);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    ALUOp = 2'b10; Opcode_field = OPC_ADD; A = 64'd7; B = 64'd9; in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || ALU_result !== 64'd16 || C !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_add: ov=%b res=%0d C=%b ir=%b exp ov=1 res=16 C=0 ir=1",
               out_valid, ALU_result, C, in_ready);
    else passed++;
    Opcode_field = OPC_SUB; A = 64'd5; B = 64'd5;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || ALU_result !== 64'd0 || Zero !== 1'b1 || C !== 1'b1 || V !== 1'b0)
      $display("FAIL b2b_sub: ov=%b res=%0d Z=%b C=%b V=%b exp ov=1 res=0 Z=1 C=1 V=0",
               out_valid, ALU_result, Zero, C, V);
    else passed++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL b2b_drop: ov=%b exp 0", out_valid);
    else passed++;
  endtask

  task automatic test_overflow_backpressure();
    int bad = 0;
    logic [W-1:0] held;
    out_ready = 1'b0;
    issue(2'b10, OPC_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    total++;
    if (ALU_result !== 64'h8000_0000_0000_0000 || N !== 1'b1 || V !== 1'b1 || C !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL ovf_add: res=%h N=%b V=%b C=%b ov=%b exp 8000000000000000 N=1 V=1 C=0 ov=1",
               ALU_result, N, V, C, out_valid);
    else passed++;
    held = 64'h8000_0000_0000_0000;
    ALUOp = 2'b00; Opcode_field = '0; A = 64'd1; B = 64'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || ALU_result !== held || V !== 1'b1) bad++;
      @(negedge clk);
    end
    total++;
    if (bad != 0)
      $display("FAIL bp_hold: %0d cycles not stalled/held, exp 0", bad);
    else passed++;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1)
      $display("FAIL bp_release_ready: ir=%b exp 1", in_ready);
    else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (ALU_result !== 64'd2 || V !== 1'b0 || N !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_next_op: res=%0d V=%b N=%b ov=%b exp res=2 V=0 N=0 ov=1",
               ALU_result, V, N, out_valid);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_logic_ops();
    out_ready = 1'b1;
    issue(2'b10, OPC_SUB, 64'd5, 64'd5);
    issue(2'b10, OPC_AND, 64'hF0F0, 64'hFF00);
    total++;
    if (ALU_result !== 64'hF000 || C !== 1'b0 || Zero !== 1'b0)
      $display("FAIL and_op: res=%h C=%b Z=%b exp f000 C=0 Z=0", ALU_result, C, Zero);
    else passed++;
    issue(2'b10, OPC_ORR, 64'hF0F0, 64'hFF00);
    total++;
    if (ALU_result !== 64'hFFF0)
      $display("FAIL orr_op: res=%h exp fff0", ALU_result);
    else passed++;
    issue(2'b10, OPC_EOR, 64'hF0F0, 64'hFF00);
    total++;
    if (ALU_result !== 64'h0FF0)
      $display("FAIL eor_op: res=%h exp 0ff0", ALU_result);
    else passed++;
    issue(2'b00, OPC_BAD, 64'd7, 64'd8);
    total++;
    if (ALU_result !== 64'd15 || illegal !== 1'b0)
      $display("FAIL aluop00_add: res=%0d ill=%b exp 15 ill=0", ALU_result, illegal);
    else passed++;
    issue(2'b11, OPC_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    total++;
    if (ALU_result !== 64'd1 || C !== 1'b1 || V !== 1'b0)
      $display("FAIL aluop11_add: res=%h C=%b V=%b exp 1 C=1 V=0", ALU_result, C, V);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_shifts();
    out_ready = 1'b1;
    issue(2'b10, OPC_LSL, 64'd1, 64'h41);
    total++;
    if (ALU_result !== 64'd2)
      $display("FAIL lsl_trunc: res=%h exp 2", ALU_result);
    else passed++;
    issue(2'b10, OPC_LSR, 64'h8000_0000_0000_0000, 64'd63);
    total++;
    if (ALU_result !== 64'd1 || N !== 1'b0)
      $display("FAIL lsr_63: res=%h N=%b exp 1 N=0", ALU_result, N);
    else passed++;
    issue(2'b10, OPC_LSR, 64'h8000_0000_0000_0000, 64'd4);
    total++;
    if (ALU_result !== 64'h0800_0000_0000_0000)
      $display("FAIL lsr_zero_fill: res=%h exp 0800000000000000", ALU_result);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_pass_illegal();
    out_ready = 1'b1;
    issue(2'b01, OPC_ADD, 64'd5, 64'd0);
    total++;
    if (ALU_result !== 64'd0 || Zero !== 1'b1)
      $display("FAIL passb_zero: res=%h Z=%b exp 0 Z=1", ALU_result, Zero);
    else passed++;
    issue(2'b01, OPC_ADD, 64'd5, 64'h1234);
    total++;
    if (ALU_result !== 64'h1234 || Zero !== 1'b0)
      $display("FAIL passb_val: res=%h Z=%b exp 1234 Z=0", ALU_result, Zero);
    else passed++;
    issue(2'b10, OPC_BAD, 64'd3, 64'd4);
    total++;
    if (illegal !== 1'b1 || ALU_result !== 64'd0 || Zero !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL illegal_op: ill=%b res=%h Z=%b ov=%b exp ill=1 res=0 Z=1 ov=1",
               illegal, ALU_result, Zero, out_valid);
    else passed++;
    issue(2'b10, OPC_ADD, 64'd2, 64'd3);
    total++;
    if (illegal !== 1'b0 || ALU_result !== 64'd5)
      $display("FAIL illegal_clear: ill=%b res=%0d exp ill=0 res=5", illegal, ALU_result);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int n;
    out_ready = 1'b1;
    issue(2'b10, OPC_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL mul_busy: ir=%b exp 0", in_ready);
    else passed++;
    wait_valid(n);
    total++;
    if (n != 65 || ALU_result !== 64'hFFFF_FFFF_FFFF_FFFD || N !== 1'b1 || C !== 1'b0)
      $display("FAIL mul_neg: lat=%0d res=%h N=%b C=%b exp lat=65 res=fffffffffffffffd N=1 C=0",
               n, ALU_result, N, C);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    int n;
    out_ready = 1'b1;
    issue(2'b10, OPC_ADD, 64'd40, 64'd2);
    issue(2'b10, OPC_MUL, 64'd3, 64'd5);
    for (int i = 0; i < 8; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALU_result !== '0 || Zero !== 1'b1)
      $display("FAIL reset_mid_mul: ov=%b ir=%b res=%h Z=%b exp ov=0 ir=1 res=0 Z=1",
               out_valid, in_ready, ALU_result, Zero);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 70; i++) @(negedge clk);
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL mul_aborted: ov=%b exp 0", out_valid);
    else passed++;
    issue(2'b10, OPC_MUL, 64'd3, 64'd5);
    wait_valid(n);
    total++;
    if (n != 65 || ALU_result !== 64'd15 || Zero !== 1'b0)
      $display("FAIL mul_reissue: lat=%0d res=%0d Z=%b exp lat=65 res=15 Z=0", n, ALU_result, Zero);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_udiv();
    out_ready = 1'b1;
`ifdef LEGV8_ALU_UDIV_EN
    begin
      int n;
      issue(2'b10, OPC_UDIV, 64'd100, 64'd7);
      wait_valid(n);
      total++;
      if (n != 65 || ALU_result !== 64'd14 || illegal !== 1'b0)
        $display("FAIL udiv_100_7: lat=%0d res=%0d ill=%b exp lat=65 res=14 ill=0", n, ALU_result, illegal);
      else passed++;
      issue(2'b10, OPC_UDIV, 64'd100, 64'd0);
      total++;
      if (out_valid !== 1'b1 || ALU_result !== 64'd0 || Zero !== 1'b1 || illegal !== 1'b0)
        $display("FAIL udiv_by_zero: ov=%b res=%h Z=%b ill=%b exp ov=1 res=0 Z=1 ill=0",
                 out_valid, ALU_result, Zero, illegal);
      else passed++;
    end
`else
    issue(2'b10, OPC_UDIV, 64'd100, 64'd7);
    total++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || ALU_result !== 64'd0)
      $display("FAIL udiv_disabled: ov=%b ill=%b res=%h exp ov=1 ill=1 res=0",
               out_valid, illegal, ALU_result);
    else passed++;
`endif
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_overflow_backpressure();
    test_logic_ops();
    test_shifts();
    test_pass_illegal();
    test_mul();
    test_reset_mid_mul();
    test_udiv();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
